cp0_exc: RTL and testbench
==========================

Name: cp0_exc

Overview:
- Next-generation system-control coprocessor. Adds precise exception entry and ERET return, BadVAddr capture, a parametrised number of hardware interrupt lines, and a masked interrupt-request output.
- Holds Count/Compare/Status/Cause/EPC/BadVAddr/Config/PRId.
- Sits beside the MEM/WB stage: takes MTC0 writes and committed exception/ERET events, serves MFC0 reads, and feeds the interrupt request back to the exception-detect logic.

Parameters:
- NUM_HW_INT, 6, number of external interrupt lines (1..6), mapped to Cause.IP[2+NUM_HW_INT-1:2].
- PRID_VAL, 32'h004C0102, PRId reset value.
- COUNT_DIV, 1, Count increments once every COUNT_DIV cycles (legal values 1 or 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- we_i  in  1  MTC0 write enable
- waddr_i  in  5  write register number
- raddr_i  in  5  read register number
- data_i  in  32  write data
- int_i  in  NUM_HW_INT  external interrupt lines, level-sensitive
- exc_valid_i  in  1  committed exception this cycle
- exc_code_i  in  5  ExcCode of the exception
- eret_i  in  1  committed ERET this cycle
- pc_i  in  32  address of the excepting instruction
- in_delayslot_i  in  1  excepting instruction is in a delay slot
- badvaddr_i  in  32  faulting address (AdEL/AdES)
- data_o  out  32  MFC0 read data
- count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, config_o, prid_o  out  32 each  register values
- timer_int_o  out  1  timer interrupt pending
- int_req_o  out  1  enabled, unmasked interrupt pending

Behaviour:
- **Reset values:** all registers 0 except:
  - Status = 32'h1000_0000 (CU0 = 1)
  - Config = 32'h0000_8000 (BE = 1)
  - PRId = PRID_VAL
  - timer_int_o = 0; data_o = 0 while rst is asserted.
- **Status bits used:** IE = bit 0, EXL = bit 1, IM = bits [15:8].
- **Cause bits used:** BD = bit 31, IP = bits [15:8], ExcCode = bits [6:2].
- **Count:**
  - Increments every COUNT_DIV cycles and wraps 32'hFFFF_FFFF -> 0.
  - For COUNT_DIV = 2 the internal phase toggle resets to 0, and an MTC0 Count write also clears the phase.
  - An MTC0 Count write overrides that cycle's increment.
- **Timer interrupt:**
  - Sets when Compare != 0 and Count == Compare; it stays set (sticky).
  - Cleared only by an MTC0 Compare write, which wins over a same-cycle set.
  - Cause.IP[7] = timer_int_o.
- **Hardware interrupts:**
  - Cause.IP[2+NUM_HW_INT-1:2] is registered from int_i every cycle.
  - IP bits above NUM_HW_INT and below 7 read as 0.
  - Cause.IP[1:0] is software-writable.
- **Writable fields:**
  - Cause: only IP[1:0], IV (bit 23) and WP (bit 22).
  - Status, EPC, Compare, Count: fully writable.
  - Config, PRId, BadVAddr: read-only; writes are ignored.
- **Event priority within one cycle:** rst > exc_valid_i > eret_i > MTC0.
  - An exception discards a same-cycle MTC0 write and any same-cycle eret_i.
  - Count increment, IP sampling and timer set continue regardless of event.
- **Exception entry (exc_valid_i):**
  - Cause.ExcCode <= exc_code_i; Status.EXL <= 1.
  - If Status.EXL was 0: EPC <= in_delayslot_i ? pc_i-4 : pc_i, and Cause.BD <= in_delayslot_i.
  - If Status.EXL was 1: EPC and BD are unchanged (nested exception).
  - If exc_code_i is 4 (AdEL) or 5 (AdES): BadVAddr <= badvaddr_i.
- **ERET:** Status.EXL <= 0. No other register changes.
- **int_req_o:** combinational from registers = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- **Read path (data_o):**
  - Combinational from raddr_i, with no bypass of same-cycle writes; a read returns the pre-write value.
  - Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config.
  - Any other address reads 0; no latch is inferred.

Decomposition:
- Shared defines header holds:
  - CP0 register numbers (adding BadVAddr = 8).
  - ExcCode constants: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
  - Status/Cause bit-position constants.
- One natural sub-module, cp0_timer: Count/Compare/COUNT_DIV/timer_int. It takes the write strobes and exports count, compare and timer_int.

Test Plan:
- **Timer:** Compare = 5 written at Count = 0 -> timer_int_o rises when Count == 5. A Compare write 3 cycles later -> timer_int_o = 0 on the next cycle. With COUNT_DIV = 2, Count = 3 after 6 cycles.
- **Wrap:** write Count = 32'hFFFF_FFFF -> next cycle Count = 0. A Count write in the same cycle as an increment -> the written value wins.
- **Exception entry:** exc_valid_i, exc_code = 4, pc = 32'h100, delay slot = 1, badvaddr = 32'h3 -> EPC = 32'hFC, BD = 1, ExcCode = 4, EXL = 1, BadVAddr = 32'h3. A second exception at pc = 32'h200 -> EPC stays 32'hFC. eret_i -> EXL = 0.
- **Interrupt gating:** Status = 32'h1000_0401, int_i[0] = 1 -> Cause.IP[2] = 1 and int_req_o = 1 the next cycle. Set EXL via an exception -> int_req_o = 0. IM = 0 -> int_req_o = 0.
- **Write filtering:** MTC0 Cause = 32'hFFFF_FFFF -> only bits 23, 22, 9, 8 change. Writes to PRId/Config/BadVAddr are ignored. Reading address 3 -> 0. An MTC0 Status write with a same-cycle exception -> write discarded, EXL = 1.
- **Reset mid-operation:** assert rst with timer_int_o = 1 and EXL = 1 -> all registers return to reset values the next cycle, and data_o = 0 while rst is asserted.

Source files
------------

// File: rtl/cp0_exc_pkg.sv
// cp0_exc_pkg: constants shared by the CP0 exception/timer block.
//   - CP0 register numbers as seen by MTC0/MFC0
//   - ExcCode values
//   - Status/Cause bit positions and reset images
package cp0_exc_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;

  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IV     = 23;
  localparam int CAUSE_WP     = 22;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_EXC_LO = 2;

  localparam logic [31:0] STATUS_RST = 32'h1000_0000;
  localparam logic [31:0] CONFIG_RST = 32'h0000_8000;

  // Address-error exceptions are the only ones that capture BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair and the sticky timer interrupt.
//   clk, rst          clock, synchronous active-high reset
//   count_we          MTC0 write to Count (already filtered by exceptions)
//   compare_we        MTC0 write to Compare (already filtered by exceptions)
//   wdata             MTC0 write data
//   count, compare    current register values
//   timer_int         sticky timer interrupt flag
module cp0_timer #(
  parameter int COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic phase;
  logic tick;

  // With COUNT_DIV == 2 Count advances on the second cycle of each phase pair.
  assign tick = (COUNT_DIV == 1) ? 1'b1 : phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      compare   <= '0;
      phase     <= 1'b0;
      timer_int <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        phase <= 1'b0;
      end else begin
        phase <= ~phase;
        if (tick) count <= count + 32'd1;
      end

      if (compare_we) compare <= wdata;

      // Compare write acknowledges the interrupt and beats a same-cycle match.
      if (compare_we)
        timer_int <= 1'b0;
      else if ((compare != '0) && (count == compare))
        timer_int <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc.sv
// cp0_exc: system-control coprocessor with precise exception entry/ERET.
//   clk, rst                 clock, synchronous active-high reset
//   we_i/waddr_i/data_i      MTC0 write port
//   raddr_i/data_o           MFC0 read port (combinational, no write bypass)
//   int_i                    level-sensitive hardware interrupt lines
//   exc_valid_i/exc_code_i   committed exception and its ExcCode
//   eret_i                   committed ERET
//   pc_i/in_delayslot_i      excepting instruction address and BD flag
//   badvaddr_i               faulting address for AdEL/AdES
//   *_o register taps        current Count..PRId values
//   timer_int_o              sticky timer interrupt
//   int_req_o                enabled, unmasked interrupt pending
module cp0_exc
  import cp0_exc_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
  parameter int          COUNT_DIV  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [4:0]            raddr_i,
  input  logic [31:0]           data_i,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic                  eret_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delayslot_i,
  input  logic [31:0]           badvaddr_i,
  output logic [31:0]           data_o,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           badvaddr_o,
  output logic [31:0]           config_o,
  output logic [31:0]           prid_o,
  output logic                  timer_int_o,
  output logic                  int_req_o
);

  logic [31:0]           status;
  logic [31:0]           epc;
  logic [31:0]           badvaddr;
  logic                  cause_bd;
  logic                  cause_iv;
  logic                  cause_wp;
  logic [1:0]            cause_ip_sw;
  logic [NUM_HW_INT-1:0] cause_ip_hw;
  logic [4:0]            cause_exc;
  logic [7:0]            ip;
  logic                  exl;

  // An exception in the same cycle kills the MTC0 write entirely.
  logic mtc0_ok;
  logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;

  assign mtc0_ok    = we_i & ~exc_valid_i;
  assign wr_status  = mtc0_ok && (waddr_i == REG_STATUS);
  assign wr_cause   = mtc0_ok && (waddr_i == REG_CAUSE);
  assign wr_epc     = mtc0_ok && (waddr_i == REG_EPC);
  assign wr_count   = mtc0_ok && (waddr_i == REG_COUNT);
  assign wr_compare = mtc0_ok && (waddr_i == REG_COMPARE);

  assign exl = status[STATUS_EXL];

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (data_i),
    .count      (count_o),
    .compare    (compare_o),
    .timer_int  (timer_int_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      status      <= STATUS_RST;
      epc         <= '0;
      badvaddr    <= '0;
      cause_bd    <= 1'b0;
      cause_iv    <= 1'b0;
      cause_wp    <= 1'b0;
      cause_ip_sw <= '0;
      cause_ip_hw <= '0;
      cause_exc   <= '0;
    end else begin
      cause_ip_hw <= int_i;

      if (exc_valid_i) begin
        status[STATUS_EXL] <= 1'b1;
        cause_exc          <= exc_code_i;
        // Nested exceptions keep the original return point.
        if (!exl) begin
          epc      <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
          cause_bd <= in_delayslot_i;
        end
        if (is_addr_exc(exc_code_i)) badvaddr <= badvaddr_i;
      end else begin
        if (wr_status) status <= data_i;
        // ERET clears EXL even if MTC0 Status wrote it in the same cycle.
        if (eret_i) status[STATUS_EXL] <= 1'b0;
        if (wr_epc) epc <= data_i;
        if (wr_cause) begin
          cause_iv    <= data_i[CAUSE_IV];
          cause_wp    <= data_i[CAUSE_WP];
          cause_ip_sw <= data_i[CAUSE_IP_LO +: 2];
        end
      end
    end
  end

  // IP[7] is shared between the timer and the top hardware line.
  always_comb begin
    ip                 = '0;
    ip[1:0]            = cause_ip_sw;
    ip[2 +: NUM_HW_INT] = cause_ip_hw;
    ip[7]              = ip[7] | timer_int_o;
  end

  always_comb begin
    cause_o                        = '0;
    cause_o[CAUSE_BD]              = cause_bd;
    cause_o[CAUSE_IV]              = cause_iv;
    cause_o[CAUSE_WP]              = cause_wp;
    cause_o[CAUSE_IP_LO +: 8]      = ip;
    cause_o[CAUSE_EXC_LO +: 5]     = cause_exc;
  end

  assign status_o   = status;
  assign epc_o      = epc;
  assign badvaddr_o = badvaddr;
  assign config_o   = CONFIG_RST;
  assign prid_o     = PRID_VAL;

  assign int_req_o = status[STATUS_IE] & ~exl & (|(ip & status[STATUS_IM_LO +: 8]));

  always_comb begin
    data_o = '0;
    if (!rst) begin
      case (raddr_i)
        REG_BADVADDR: data_o = badvaddr;
        REG_COUNT:    data_o = count_o;
        REG_COMPARE:  data_o = compare_o;
        REG_STATUS:   data_o = status;
        REG_CAUSE:    data_o = cause_o;
        REG_EPC:      data_o = epc;
        REG_PRID:     data_o = PRID_VAL;
        REG_CONFIG:   data_o = CONFIG_RST;
        default:      data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc.sv
module tb_cp0_exc;

  localparam int C_STATUS = 0, C_CAUSE = 1, C_EPC = 2, C_BVA = 3, C_COUNT = 4,
                 C_CMP = 5, C_PRID = 6, C_CFG = 7, C_TMR = 8, C_IRQ = 9, C_DATA = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr, raddr;
  logic [31:0] wdata;
  logic [5:0]  intv;
  logic        exc;
  logic [4:0]  code;
  logic        eret;
  logic [31:0] pc;
  logic        ds;
  logic [31:0] bva;

  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, config_o, prid_o;
  logic        timer_int_o, int_req_o;

  // Second instance with COUNT_DIV = 2, held idle.
  logic        z1 = 1'b0;
  logic [4:0]  z5 = 5'd0;
  logic [31:0] z32 = 32'd0;
  logic [5:0]  z6 = 6'd0;
  logic [31:0] d2_data, d2_count, d2_compare, d2_status, d2_cause, d2_epc, d2_bva, d2_config, d2_prid;
  logic        d2_timer, d2_irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cp0_exc dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .raddr_i(raddr), .data_i(wdata),
    .int_i(intv), .exc_valid_i(exc), .exc_code_i(code), .eret_i(eret), .pc_i(pc),
    .in_delayslot_i(ds), .badvaddr_i(bva), .data_o(data_o), .count_o(count_o),
    .compare_o(compare_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .badvaddr_o(badvaddr_o), .config_o(config_o), .prid_o(prid_o),
    .timer_int_o(timer_int_o), .int_req_o(int_req_o)
  );

  cp0_exc #(.COUNT_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .we_i(z1), .waddr_i(z5), .raddr_i(z5), .data_i(z32),
    .int_i(z6), .exc_valid_i(z1), .exc_code_i(z5), .eret_i(z1), .pc_i(z32),
    .in_delayslot_i(z1), .badvaddr_i(z32), .data_o(d2_data), .count_o(d2_count),
    .compare_o(d2_compare), .status_o(d2_status), .cause_o(d2_cause), .epc_o(d2_epc),
    .badvaddr_o(d2_bva), .config_o(d2_config), .prid_o(d2_prid),
    .timer_int_o(d2_timer), .int_req_o(d2_irq)
  );

  // ---------------- reference model (architectural state) ----------------
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_bva;
  logic        m_timer;

  task automatic m_reset();
    m_count = 0; m_compare = 0; m_status = 32'h1000_0000; m_cause = 0;
    m_epc = 0; m_bva = 0; m_timer = 0;
  endtask

  // Cause as software sees it: stored bits plus the timer folded into IP7.
  function automatic logic [31:0] m_cause_view();
    return m_cause | {16'd0, m_timer, 15'd0};
  endfunction

  function automatic logic m_irq();
    logic [31:0] c;
    c = m_cause_view();
    return m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 8'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_bva;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause_view();
      5'd14: return m_epc;
      5'd15: return 32'h004C_0102;
      5'd16: return 32'h0000_8000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: check the read path, advance the model by the rules, compare state.
  task automatic step();
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc, n_bva;
    logic        n_timer, w;
    #1;
    check("data_o", data_o, rst ? 32'd0 : m_read(raddr));
    w = we && !exc;
    n_count   = (w && waddr == 5'd9) ? wdata : m_count + 1;
    n_compare = (w && waddr == 5'd11) ? wdata : m_compare;
    if (w && waddr == 5'd11) n_timer = 0;
    else if (m_compare != 0 && m_count == m_compare) n_timer = 1;
    else n_timer = m_timer;
    n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_bva = m_bva;
    if (exc) begin
      n_status = n_status | 32'h2;
      n_cause = (n_cause & ~32'h7C) | {25'd0, code, 2'b00};
      if (!m_status[1]) begin
        n_epc = ds ? pc - 4 : pc;
        n_cause = (n_cause & 32'h7FFF_FFFF) | {ds, 31'd0};
      end
      if (code == 5'd4 || code == 5'd5) n_bva = bva;
    end else begin
      if (w && waddr == 5'd12) n_status = wdata;
      if (eret) n_status = n_status & ~32'h2;
      if (w && waddr == 5'd13) n_cause = (n_cause & ~32'h00C0_0300) | (wdata & 32'h00C0_0300);
      if (w && waddr == 5'd14) n_epc = wdata;
    end
    n_cause = (n_cause & ~32'h0000_FC00) | {16'd0, intv, 10'd0};
    @(posedge clk); #1;
    if (rst) m_reset();
    else begin
      m_count = n_count; m_compare = n_compare; m_timer = n_timer; m_status = n_status;
      m_cause = n_cause; m_epc = n_epc; m_bva = n_bva;
    end
    check("count", count_o, m_count);
    check("compare", compare_o, m_compare);
    check("status", status_o, m_status);
    check("cause", cause_o, m_cause_view());
    check("epc", epc_o, m_epc);
    check("badvaddr", badvaddr_o, m_bva);
    check("config", config_o, 32'h0000_8000);
    check("prid", prid_o, 32'h004C_0102);
    check("timer_int", {31'd0, timer_int_o}, {31'd0, m_timer});
    check("int_req", {31'd0, int_req_o}, {31'd0, m_irq()});
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0; exc = 0; code = 0; eret = 0; pc = 0; ds = 0; bva = 0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        ds;
    logic        eret;
    logic [4:0]  ra;
    int          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic e, input logic [4:0] c, input logic [31:0] p,
                              input logic d, input logic er, input logic [4:0] ra,
                              input int chk, input logic [31:0] exp);
    vec_t v;
    v.we = w; v.wa = wa; v.wd = wd; v.exc = e; v.code = c; v.pc = p; v.ds = d;
    v.eret = er; v.ra = ra; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      C_STATUS: return status_o;
      C_CAUSE:  return cause_o;
      C_EPC:    return epc_o;
      C_BVA:    return badvaddr_o;
      C_COUNT:  return count_o;
      C_CMP:    return compare_o;
      C_PRID:   return prid_o;
      C_CFG:    return config_o;
      C_TMR:    return {31'd0, timer_int_o};
      C_IRQ:    return {31'd0, int_req_o};
      default:  return data_o;
    endcase
  endfunction

  initial begin
    logic [4:0] addrs [10];
    logic [4:0] codes [7];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3, 5'd0};
    codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

    tbl.push_back(mk(1, 12, 32'h1000_0401, 0, 0, 0, 0, 0, 0, C_STATUS, 32'h1000_0401));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_IRQ, 32'd1));
    tbl.push_back(mk(0, 0, 0, 1, 4, 32'h100, 1, 0, 0, C_EPC, 32'h0000_00FC));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_CAUSE, 32'h8000_0410));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_STATUS, 32'h1000_0403));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_BVA, 32'h3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_IRQ, 32'd0));
    tbl.push_back(mk(0, 0, 0, 1, 8, 32'h200, 0, 0, 0, C_EPC, 32'h0000_00FC));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_CAUSE, 32'h8000_0420));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_STATUS, 32'h1000_0401));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_IRQ, 32'd1));
    tbl.push_back(mk(1, 12, 32'h1000_0001, 0, 0, 0, 0, 0, 0, C_IRQ, 32'd0));
    tbl.push_back(mk(1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, C_CAUSE, 32'h80C0_0720));
    tbl.push_back(mk(1, 15, 32'h0, 0, 0, 0, 0, 0, 0, C_PRID, 32'h004C_0102));
    tbl.push_back(mk(1, 16, 32'h0, 0, 0, 0, 0, 0, 0, C_CFG, 32'h0000_8000));
    tbl.push_back(mk(1, 8, 32'hDEAD, 0, 0, 0, 0, 0, 0, C_BVA, 32'h3));
    tbl.push_back(mk(1, 12, 32'h0, 1, 12, 32'h300, 0, 0, 0, C_STATUS, 32'h1000_0003));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_EPC, 32'h300));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, C_DATA, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 14, C_DATA, 32'h300));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 15, C_DATA, 32'h004C_0102));
    tbl.push_back(mk(1, 9, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, C_COUNT, 32'hFFFF_FFFF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_COUNT, 32'h0));
    tbl.push_back(mk(1, 9, 32'h10, 0, 0, 0, 0, 0, 0, C_COUNT, 32'h10));
    tbl.push_back(mk(1, 9, 32'h0, 0, 0, 0, 0, 0, 0, C_COUNT, 32'h0));
    tbl.push_back(mk(1, 11, 32'h5, 0, 0, 0, 0, 0, 0, C_CMP, 32'h5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_COUNT, 32'h2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_COUNT, 32'h3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_COUNT, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_TMR, 32'd0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_TMR, 32'd1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_CAUSE, 32'h00C0_8730));
    tbl.push_back(mk(1, 11, 32'h100, 0, 0, 0, 0, 0, 0, C_TMR, 32'd0));

    // Reset values, and data_o forced to 0 during reset.
    idle(); intv = 0; raddr = 5'd12; rst = 1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_o", data_o, 32'd0);
    check("rst_status", status_o, 32'h1000_0000);
    check("rst_config", config_o, 32'h0000_8000);
    check("rst_prid", prid_o, 32'h004C_0102);
    check("rst_count", count_o, 32'd0);
    check("rst_timer", {31'd0, timer_int_o}, 32'd0);
    rst = 0;
    intv = 6'b000001;

    for (int i = 0; i < tbl.size(); i++) begin
      we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd; exc = tbl[i].exc;
      code = tbl[i].code; pc = tbl[i].pc; ds = tbl[i].ds; eret = tbl[i].eret;
      raddr = tbl[i].ra; bva = 32'h3;
      if (tbl[i].chk == C_DATA) begin
        #1;
        check($sformatf("vec%0d_data", i), data_o, tbl[i].exp);
      end
      step();
      if (tbl[i].chk != C_DATA)
        check($sformatf("vec%0d", i), pick(tbl[i].chk), tbl[i].exp);
      if (i == 5) begin
        // Divide-by-two Count after six cycles out of reset; rest still at reset.
        check("div2_count", d2_count, 32'd3);
        check("div2_compare", d2_compare, 32'd0);
        check("div2_status", d2_status, 32'h1000_0000);
        check("div2_cause", d2_cause, 32'd0);
        check("div2_epc", d2_epc | d2_bva, 32'd0);
        check("div2_cfg", d2_config, 32'h0000_8000);
        check("div2_prid", d2_prid, 32'h004C_0102);
        check("div2_data", d2_data, 32'd0);
        check("div2_flags", {30'd0, d2_timer, d2_irq}, 32'd0);
      end
    end

    // Reset in the middle of operation with the timer pending and EXL set.
    idle(); we = 1; waddr = 5'd11; wdata = 32'd3; step();
    idle(); we = 1; waddr = 5'd9;  wdata = 32'd3; step();
    idle(); step();
    check("pre_rst_timer", {31'd0, timer_int_o}, 32'd1);
    idle(); exc = 1; code = 5'd0; pc = 32'h400; step();
    check("pre_rst_exl", {31'd0, status_o[1]}, 32'd1);
    idle(); rst = 1; raddr = 5'd12;
    #1;
    check("mid_rst_data_o", data_o, 32'd0);
    step();
    check("post_rst_status", status_o, 32'h1000_0000);
    check("post_rst_timer", {31'd0, timer_int_o}, 32'd0);
    check("post_rst_cause", cause_o, 32'd0);
    check("post_rst_epc", epc_o, 32'd0);
    rst = 0;

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      idle();
      we    = ($urandom_range(0, 2) == 0);
      waddr = addrs[$urandom_range(0, 9)];
      wdata = $urandom;
      if (waddr == 5'd11 && $urandom_range(0, 1) == 1) wdata = m_count + $urandom_range(1, 4);
      if (waddr == 5'd12 && $urandom_range(0, 1) == 1) wdata = {16'h1000, 8'($urandom), 6'd0, 2'($urandom)};
      exc   = ($urandom_range(0, 11) == 0);
      code  = codes[$urandom_range(0, 6)];
      eret  = ($urandom_range(0, 9) == 0);
      pc    = {$urandom_range(0, 32'h0000_FFFF), 2'b00};
      ds    = 1'($urandom);
      bva   = $urandom;
      intv  = 6'($urandom);
      raddr = addrs[$urandom_range(0, 9)];
      rst   = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
